// File: rtl/rr_arb_pkg.sv
// Shared constants and state type for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set request bit at or after ptr, modulo N.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Walk the search order backwards so the lowest offset from ptr wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter producing registered select/enable for a 3-to-8 grant decoder.
module rr_arbiter_8 #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [IDX_W-1:0] sel,
  output logic             en,
  output logic             timeout
);

  localparam int unsigned CNT_W = 8;

  rr_arb_pkg::state_e state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               limit_c;
  logic               release_c;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Owner gives up the grant on done, withdrawal, or reaching the hold limit.
  assign limit_c   = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign release_c = done | ~req[sel] | limit_c;

  // Grant FSM with pointer rotation and hold counter; all outputs are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= rr_arb_pkg::IDLE;
      sel      <= '0;
      en       <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        rr_arb_pkg::IDLE: begin
          timeout <= 1'b0;
          if (pick_any) begin
            state    <= rr_arb_pkg::GRANT;
            sel      <= pick_idx;
            en       <= 1'b1;
            hold_cnt <= '0;
          end
        end
        rr_arb_pkg::GRANT: begin
          if (release_c) begin
            state   <= rr_arb_pkg::IDLE;
            en      <= 1'b0;
            ptr     <= sel + IDX_W'(1);
            timeout <= limit_c;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
            timeout  <= 1'b0;
          end
        end
        default: begin
          state   <= rr_arb_pkg::IDLE;
          en      <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule : rr_arbiter_8

// File: tb/tb_rr_arbiter_8.sv
// Directed and randomized check of rr_arbiter_8 against a cycle-level reference model.
module tb_rr_arbiter_8;

  localparam int unsigned MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       en;
  logic       timeout;

  int n_cmp;
  int n_err;

  // Reference model state (plain integers)
  int m_en, m_sel, m_to, m_ptr, m_hold;

  rr_arbiter_8 #(.N(8), .IDX_W(3), .MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .en      (en),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit found;
    int w;
    bit lim;
    if (rst) begin
      m_en = 0; m_sel = 0; m_to = 0; m_ptr = 0; m_hold = 0;
    end else if (m_en == 0) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        w = (m_ptr + k) % 8;
        if (!found && req[w]) begin
          found  = 1;
          m_sel  = w;
          m_en   = 1;
          m_hold = 0;
        end
      end
    end else begin
      lim = (m_hold == MAXH - 1);
      if (done || !req[m_sel] || lim) begin
        m_en  = 0;
        m_ptr = (m_sel + 1) % 8;
        m_to  = lim ? 1 : 0;
      end else begin
        m_hold = m_hold + 1;
        m_to   = 0;
      end
    end
  endtask

  // One clock: update model on the edge, sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_en", 32'(en), 32'(m_en));
    check("model_sel", 32'(sel), 32'(m_sel));
    check("model_timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_en = 0; m_sel = 0; m_to = 0; m_ptr = 0; m_hold = 0;
    rst = 1'b1; req = 8'hFF; done = 1'b0;

    // 1. Reset with all requests high
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_en", 32'(en), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
    end
    rst = 1'b0;
    step();
    check("first_grant_en", 32'(en), 32'd1);
    check("first_grant_sel", 32'(sel), 32'd0);

    // 2. Rotation with done pulsed one cycle after each grant
    for (int i = 1; i <= 8; i++) begin
      done = 1'b1;
      step();
      check("rot_gap_en", 32'(en), 32'd0);
      done = 1'b0;
      step();
      check("rot_en", 32'(en), 32'd1);
      check("rot_sel", 32'(sel), 32'(i % 8));
    end

    // 3. Wrap priority
    done = 1'b1; step();
    done = 1'b0; req = 8'h40; step();
    check("wrap_grant6", 32'(sel), 32'd6);
    done = 1'b1; step();
    done = 1'b0; req = 8'b0000_0011; step();
    check("wrap_sel0_en", 32'(en), 32'd1);
    check("wrap_sel0", 32'(sel), 32'd0);
    done = 1'b1; step();
    done = 1'b0; req = 8'b1000_0001; step();
    check("wrap_sel7", 32'(sel), 32'd7);
    done = 1'b1; step();
    done = 1'b0;

    // 4. Timeout with requester 3 holding
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_en", 32'(en), 32'd1);
      check("hold_sel", 32'(sel), 32'd3);
      check("hold_no_to", 32'(timeout), 32'd0);
    end
    step();
    check("to_en_drop", 32'(en), 32'd0);
    check("to_pulse", 32'(timeout), 32'd1);
    step();
    check("to_regrant_en", 32'(en), 32'd1);
    check("to_regrant_sel", 32'(sel), 32'd3);
    check("to_pulse_end", 32'(timeout), 32'd0);

    // 5a. Withdrawal mid-grant
    done = 1'b1; step();
    done = 1'b0; req = 8'h20; step();
    check("wd_grant5", 32'(sel), 32'd5);
    step();
    req = 8'h00; step();
    check("wd_en_drop", 32'(en), 32'd0);
    check("wd_no_to", 32'(timeout), 32'd0);

    // 5b. done coinciding with the timeout cycle
    req = 8'h20; step();
    check("sim_grant", 32'(en), 32'd1);
    for (int i = 0; i < 3; i++) step();
    done = 1'b1; step();
    check("sim_en_drop", 32'(en), 32'd0);
    check("sim_to", 32'(timeout), 32'd1);
    done = 1'b0; step();
    check("sim_single_to", 32'(timeout), 32'd0);

    // 6. Reset while requester 4 owns the grant
    done = 1'b1; step();
    done = 1'b0; req = 8'h10; step();
    check("mr_grant4_en", 32'(en), 32'd1);
    check("mr_grant4_sel", 32'(sel), 32'd4);
    rst = 1'b1; step();
    check("mr_en", 32'(en), 32'd0);
    check("mr_sel", 32'(sel), 32'd0);
    rst = 1'b0; req = 8'h11; step();
    check("mr_first_sel", 32'(sel), 32'd0);
    check("mr_first_en", 32'(en), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rr_arbiter_8
